// File: rtl/cpu_ahb_master.sv
// Single-outstanding AHB-Lite master bridging a simple CPU request/ack port.
// Optional HREADY timeout abort is compiled in with `define CPU_AHB_TIMEOUT_EN.
module cpu_ahb_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t      state, state_nx;
  logic [31:0] wdata_q, wdata_nx, haddr_nx, hwdata_nx, rdata_nx;
  logic [1:0]  htrans_nx;
  logic [2:0]  hsize_nx;
  logic        hwrite_nx, ack_nx, err_nx, legal, to_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  // Little-endian lane placement of right-justified CPU data onto the bus
  function automatic logic [31:0] lane_wr(input logic [1:0] sz, input logic [1:0] a,
                                          input logic [31:0] d);
    case (sz)
      2'b00:   lane_wr = {24'h0, d[7:0]} << {a, 3'b000};
      2'b01:   lane_wr = {16'h0, d[15:0]} << {a[1], 4'b0000};
      default: lane_wr = d;
    endcase
  endfunction

  function automatic logic [31:0] lane_rd(input logic [1:0] sz, input logic [1:0] a,
                                          input logic [31:0] d);
    case (sz)
      2'b00:   lane_rd = (d >> {a, 3'b000}) & 32'h0000_00FF;
      2'b01:   lane_rd = (d >> {a[1], 4'b0000}) & 32'h0000_FFFF;
      default: lane_rd = d;
    endcase
  endfunction

  assign legal = (cpu_size == 2'b00) ||
                 (cpu_size == 2'b01 && !cpu_addr[0]) ||
                 (cpu_size == 2'b10 && cpu_addr[1:0] == 2'b00);

  assign cpu_busy = (state != IDLE);
  assign HBURST   = 3'b000;

`ifdef CPU_AHB_TIMEOUT_EN
  logic [7:0] to_cnt, to_cnt_nx;
  assign to_hit    = cpu_busy && !HREADY && (to_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign to_cnt_nx = (!cpu_busy || HREADY || to_hit) ? 8'd0 : to_cnt + 8'd1;

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) to_cnt <= 8'd0;
    else          to_cnt <= to_cnt_nx;
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    haddr_nx  = HADDR;
    htrans_nx = HTRANS;
    hwrite_nx = HWRITE;
    hsize_nx  = HSIZE;
    hwdata_nx = HWDATA;
    wdata_nx  = wdata_q;
    ack_nx    = 1'b0;
    err_nx    = cpu_err;
    rdata_nx  = cpu_rdata;
    case (state)
      IDLE:
        if (cpu_req) begin
          if (legal) begin
            state_nx  = ADDR;
            htrans_nx = 2'b10;
            haddr_nx  = cpu_addr;
            hwrite_nx = cpu_we;
            hsize_nx  = {1'b0, cpu_size};
            wdata_nx  = cpu_wdata;
          end else begin
            // Rejected locally: error ack without touching the bus
            ack_nx   = 1'b1;
            err_nx   = 1'b1;
            rdata_nx = 32'h0;
          end
        end
      ADDR:
        if (to_hit) begin
          state_nx  = IDLE;
          htrans_nx = 2'b00;
          ack_nx    = 1'b1;
          err_nx    = 1'b1;
          rdata_nx  = 32'h0;
        end else if (HREADY) begin
          state_nx  = DATA;
          htrans_nx = 2'b00;
          hwdata_nx = HWRITE ? lane_wr(HSIZE[1:0], HADDR[1:0], wdata_q) : 32'h0;
        end
      DATA:
        if (to_hit) begin
          state_nx  = IDLE;
          htrans_nx = 2'b00;
          ack_nx    = 1'b1;
          err_nx    = 1'b1;
          rdata_nx  = 32'h0;
        end else if (HREADY) begin
          state_nx = IDLE;
          ack_nx   = 1'b1;
          err_nx   = HRESP;
          rdata_nx = HWRITE ? 32'h0 : lane_rd(HSIZE[1:0], HADDR[1:0], HRDATA);
        end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state     <= IDLE;
      HADDR     <= 32'h0;
      HTRANS    <= 2'b00;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b000;
      HWDATA    <= 32'h0;
      wdata_q   <= 32'h0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= 32'h0;
    end else begin
      state     <= state_nx;
      HADDR     <= haddr_nx;
      HTRANS    <= htrans_nx;
      HWRITE    <= hwrite_nx;
      HSIZE     <= hsize_nx;
      HWDATA    <= hwdata_nx;
      wdata_q   <= wdata_nx;
      cpu_ack   <= ack_nx;
      cpu_err   <= err_nx;
      cpu_rdata <= rdata_nx;
    end

endmodule

// File: tb/tb_cpu_ahb_master.sv
// Scoreboard bench for cpu_ahb_master: stimulus pushes expected acks, a negedge
// monitor pops and compares; bus-phase values are checked inline.
module tb_cpu_ahb_master;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_busy, cpu_ack, cpu_err;
  logic [31:0] cpu_rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  cpu_ahb_master #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          at;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Monitor: every ack must match the oldest expectation, including its cycle
  always @(negedge HCLK) begin
    check("hburst", {29'h0, HBURST}, 32'h0);
    check("htrans_kind", {31'h0, HTRANS[0]}, 32'h0);
    if (HRESETn && cpu_ack) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack at cycle %0d want none", cyc);
      end else begin
        e = sbq.pop_front();
        check("ack_cycle", cyc, e.at);
        check("cpu_err", {31'h0, cpu_err}, {31'h0, e.err});
        check("cpu_rdata", cpu_rdata, e.rd);
      end
    end
  end

  // One CPU transfer issued in the current cycle; waits = HREADY-low data cycles
  task automatic xfer(input logic we, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input int waits, input logic [31:0] hr,
                      input logic eresp, input logic [31:0] exp_hw, input logic exp_err,
                      input logic [31:0] exp_rd, input logic legal);
    int c0;
    c0 = cyc;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_size = sz; cpu_wdata = wd;
    HREADY = 1'b1; HRESP = 1'b0;
    sbq.push_back('{exp_err, exp_rd, c0 + (legal ? 3 + waits : 1)});
    step();
    cpu_req = 1'b0; cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'hDEAD_BEEF; cpu_size = 2'b11;
    if (!legal) begin
      check("illegal_htrans", {30'h0, HTRANS}, 32'h0);
      check("illegal_busy", {31'h0, cpu_busy}, 32'h0);
      return;
    end
    check("addr_htrans", {30'h0, HTRANS}, 32'h2);
    check("addr_haddr", HADDR, a);
    check("addr_hwrite", {31'h0, HWRITE}, {31'h0, we});
    check("addr_hsize", {29'h0, HSIZE}, {30'h0, sz});
    check("addr_busy", {31'h0, cpu_busy}, 32'h1);
    step();
    check("data_htrans", {30'h0, HTRANS}, 32'h0);
    if (we) check("data_hwdata", HWDATA, exp_hw);
    HRDATA = hr;
    for (int i = 0; i < waits; i++) begin
      HREADY = 1'b0; HRESP = eresp;
      step();
      check("wait_busy", {31'h0, cpu_busy}, 32'h1);
      check("wait_htrans", {30'h0, HTRANS}, 32'h0);
    end
    HREADY = 1'b1; HRESP = eresp;
    step();
    HRESP = 1'b0;
    check("ack_busy", {31'h0, cpu_busy}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    step(); step();
    check("rst_busy", {31'h0, cpu_busy}, 32'h0);
    check("rst_htrans", {30'h0, HTRANS}, 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_ack", {31'h0, cpu_ack}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    HRESETn = 1'b1;
    step();

    // word write, zero wait
    xfer(1'b1, 32'h2000_0000, 2'b10, 32'h0000_00A5, 0, 32'h0, 1'b0, 32'h0000_00A5, 1'b0, 32'h0, 1'b1);
    // byte read lane 2, two wait states
    xfer(1'b0, 32'h2000_0002, 2'b00, 32'h0, 2, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 32'h0000_0022, 1'b1);
    // byte write lane 1 with junk in upper CPU bits
    xfer(1'b1, 32'h4000_0001, 2'b00, 32'hFFFF_FF5A, 0, 32'h0, 1'b0, 32'h0000_5A00, 1'b0, 32'h0, 1'b1);
    // halfword write upper lanes, back-to-back
    xfer(1'b1, 32'h4000_0002, 2'b01, 32'h1234_BEEF, 0, 32'h0, 1'b0, 32'hBEEF_0000, 1'b0, 32'h0, 1'b1);
    xfer(1'b0, 32'h4000_0002, 2'b01, 32'h0, 0, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 32'h0000_1122, 1'b1);
    xfer(1'b0, 32'h4000_0003, 2'b00, 32'h0, 1, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0, 32'h0000_00AA, 1'b1);
    xfer(1'b0, 32'h4000_0000, 2'b10, 32'h0, 0, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0, 32'hAABB_CCDD, 1'b1);
    // illegal requests
    xfer(1'b1, 32'h1000_0003, 2'b01, 32'h1, 0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    xfer(1'b0, 32'h1000_0000, 2'b11, 32'h0, 0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    xfer(1'b0, 32'h1000_0002, 2'b10, 32'h0, 0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    // two-cycle ERROR response on a read
    xfer(1'b0, 32'h6000_0000, 2'b10, 32'h0, 1, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1);

    // reset during a stalled data phase: outputs clear at once, no ack later
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h5000_0000; cpu_size = 2'b10;
    cpu_wdata = 32'h1234_5678; HREADY = 1'b1;
    step();
    cpu_req = 1'b0;
    step();
    HREADY = 1'b0;
    check("pre_rst_hwdata", HWDATA, 32'h1234_5678);
    #2 HRESETn = 1'b0;
    #1;
    check("arst_busy", {31'h0, cpu_busy}, 32'h0);
    check("arst_htrans", {30'h0, HTRANS}, 32'h0);
    check("arst_haddr", HADDR, 32'h0);
    check("arst_hwdata", HWDATA, 32'h0);
    check("arst_hwrite", {31'h0, HWRITE}, 32'h0);
    check("arst_hsize", {29'h0, HSIZE}, 32'h0);
    step(); step();
    HREADY = 1'b1; HRESETn = 1'b1;
    xfer(1'b1, 32'h5000_0004, 2'b10, 32'h0BAD_F00D, 0, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b1);

`ifdef CPU_AHB_TIMEOUT_EN
    begin
      int c0;
      c0 = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000_0000; cpu_size = 2'b10; HREADY = 1'b1;
      sbq.push_back('{1'b1, 32'h0, c0 + 6});
      step();
      cpu_req = 1'b0;
      step();
      HREADY = 1'b0;
      repeat (4) step();
      check("timeout_busy", {31'h0, cpu_busy}, 32'h0);
      check("timeout_htrans", {30'h0, HTRANS}, 32'h0);
      HREADY = 1'b1;
    end
`else
    // no timeout: long stall just waits, then completes normally
    xfer(1'b0, 32'h3000_0000, 2'b10, 32'h0, 20, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1);
`endif

    step(); step();
    check("sb_drained", sbq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_ahb_master.md
CPU_AHB_MASTER -- requirements
Module: cpu_ahb_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max consecutive HREADY-low cycles before abort (used only with CPU_AHB_TIMEOUT_EN; range 1-255, 8-bit counter).
REQ-002 SHALL have ports (name direction width meaning):
 HCLK  in  1  clock, all logic on rising edge
 HRESETn  in  1  reset, asynchronous, active-low
 cpu_req  in  1  CPU request strobe
 cpu_we  in  1  1=write, 0=read
 cpu_addr  in  32  byte address
 cpu_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
 cpu_wdata  in  32  write data, right-justified
 cpu_busy  out  1  transfer in progress, request not accepted
 cpu_ack  out  1  one-cycle completion pulse
 cpu_err  out  1  error status, valid with cpu_ack
 cpu_rdata  out  32  read data, right-justified, zero-extended, valid with cpu_ack
 HADDR  out  32  AHB address
 HTRANS  out  2  AHB transfer type
 HWRITE  out  1  AHB direction
 HSIZE  out  3  AHB size
 HBURST  out  3  constant 000 (SINGLE)
 HWDATA  out  32  AHB write data
 HRDATA  in  32  AHB read data
 HREADY  in  1  AHB ready
 HRESP  in  1  AHB response, 1=ERROR

Function
REQ-003 SHALL implement FSM IDLE, ADDR, DATA; at most one outstanding transfer.
REQ-004 SHALL accept a request when state=IDLE and cpu_req=1; cpu_we/addr/size/wdata captured at that edge; later input changes ignored until next acceptance.
REQ-005 SHALL drive cpu_busy=1 in ADDR and DATA, 0 in IDLE; cpu_req while busy SHALL be ignored (no queuing).
REQ-006 SHALL, on acceptance of an aligned legal request, enter ADDR: HTRANS=10 (NONSEQ), HADDR=captured address, HWRITE=cpu_we, HSIZE={1'b0,cpu_size}.
REQ-007 SHALL hold ADDR outputs stable until HREADY=1 sampled in ADDR, then enter DATA with HTRANS=00.
REQ-008 SHALL drive HWDATA in DATA with data placed on the addressed byte lane, little-endian: byte -> lane addr[1:0], halfword -> lanes addr[1]*2..+1, word -> all lanes; unused lanes 0.
REQ-009 SHALL complete DATA on the first cycle with HREADY=1; at the next edge: state=IDLE, cpu_ack=1 for one cycle, cpu_err=HRESP sampled at completion, cpu_rdata = addressed lane(s) of HRDATA zero-extended for reads, 0 for writes.
REQ-010 SHALL give zero-wait latency: request cycle 0, address phase cycle 1, data phase cycle 2, cpu_ack cycle 3; each HREADY-low cycle adds one cycle.
REQ-011 SHALL, on HRESP=1 with HREADY=0 (first error cycle), keep HTRANS=00 and wait; completion on the second cycle reports cpu_err=1.
REQ-012 SHALL treat cpu_size=11, halfword with addr[0]=1, or word with addr[1:0]!=0 as illegal: no AHB transfer (HTRANS stays 00), cpu_ack=1 and cpu_err=1 on the next cycle, state stays IDLE.
REQ-013 SHALL allow a new request in the cycle cpu_ack=1 (state is IDLE), giving back-to-back transfers every 3 cycles.
REQ-014 SHALL hold HBURST=000 at all times and drive HTRANS only 00 or 10.

Reset
REQ-015 SHALL on HRESETn=0, regardless of state, immediately set: state IDLE, HADDR 0, HTRANS 00, HWRITE 0, HSIZE 000, HWDATA 0, cpu_busy 0, cpu_ack 0, cpu_err 0, cpu_rdata 0, timeout counter 0.
REQ-016 SHALL abandon an in-flight transfer on reset with no cpu_ack after release; first acceptance is possible in the first cycle after deassertion.

Configuration
REQ-017 SHALL, with CPU_AHB_TIMEOUT_EN defined, count consecutive HREADY=0 cycles in ADDR/DATA (clear on HREADY=1 or IDLE); on reaching TIMEOUT_CYCLES SHALL drive HTRANS=00, return to IDLE, and pulse cpu_ack=1 with cpu_err=1, cpu_rdata=0.
REQ-018 SHALL, without CPU_AHB_TIMEOUT_EN, contain no counter, ignore TIMEOUT_CYCLES, and wait on HREADY indefinitely.

Verification
REQ-019 Word write 0x20000000, data 0x000000A5, HREADY=1 -> NONSEQ cycle 1, HWDATA=0x000000A5 cycle 2, cpu_ack=1 cpu_err=0 cycle 3.
REQ-020 Byte read 0x20000002, HRDATA=0x11223344, 2 wait states -> HSIZE=000, cpu_ack cycle 5, cpu_rdata=0x00000022.
REQ-021 Halfword write 0x10000003 -> no NONSEQ, cpu_ack=1 cpu_err=1 next cycle; size=11 likewise.
REQ-022 Slave returns HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on a read -> cpu_ack=1, cpu_err=1, HTRANS=00 throughout error.
REQ-023 HRESETn low in DATA with HREADY=0 -> all outputs at reset values immediately, no cpu_ack after release; back-to-back writes -> NONSEQ every 3 cycles.
REQ-024 With CPU_AHB_TIMEOUT_EN, TIMEOUT_CYCLES=4, HREADY held 0 in DATA -> cpu_ack=1 cpu_err=1 after 4 low cycles; without macro, cpu_busy stays 1.
